// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: redirect/kill/stall arbitration, halt drain.
// Optional perf counters are enabled with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int KILL_CYCLES  = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_req,
  input  logic [31:0] flush_addr,
  input  logic        ex_brch,
  input  logic [31:0] ex_target,
  input  logic        dec_stall,
  input  logic        fetch_over,
  output logic [34:0] ctrbus,
  output logic        misalign,
  output logic        halted,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  kill_cnt, kill_cnt_next;
  logic [3:0]  drain_cnt, drain_cnt_next;
  logic        redir;
  logic [31:0] src;
  logic        valid, brch, kill;
  logic [31:0] brchaddr;

  assign src = flush_req ? flush_addr : ex_target;

  always_comb begin
    redir          = (flush_req | ex_brch) && (state != HALTED);
    valid          = 1'b0;
    brch           = 1'b0;
    kill           = 1'b0;
    brchaddr       = '0;
    state_next     = state;
    drain_cnt_next = drain_cnt;
    kill_cnt_next  = (kill_cnt != 3'd0) ? kill_cnt - 3'd1 : 3'd0;

    if (redir) begin
      brch          = 1'b1;
      kill          = 1'b1;
      brchaddr      = {src[31:2], 2'b00};
      valid         = (state == RUN);
      kill_cnt_next = 3'(KILL_CYCLES - 1);
    end else if (state != HALTED) begin
      kill  = (kill_cnt != 3'd0);
      valid = (state == RUN) && !dec_stall;
    end

    case (state)
      RUN: begin
        if (fetch_over && !redir) begin
          state_next     = DRAIN;
          drain_cnt_next = 4'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) state_next = HALTED;
        else drain_cnt_next = drain_cnt - 4'd1;
      end
      default: state_next = HALTED;
    endcase

    // The bus is forced idle while reset is held, regardless of stale state.
    if (reset) begin
      valid    = 1'b0;
      brch     = 1'b0;
      kill     = 1'b0;
      brchaddr = '0;
    end
  end

  assign ctrbus = {valid, brch, kill, brchaddr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      kill_cnt  <= '0;
      drain_cnt <= '0;
      halted    <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state     <= state_next;
      kill_cnt  <= kill_cnt_next;
      drain_cnt <= drain_cnt_next;
      halted    <= (state_next == HALTED);
      misalign  <= redir && (src[1:0] != 2'b00);
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] redirect_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_q <= '0;
      stall_q    <= '0;
    end else begin
      if (brch) redirect_q <= redirect_q + 32'd1;
      if (state == RUN && !valid) stall_q <= stall_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_q;
  assign stall_cnt    = stall_q;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with KILL_CYCLES=2, DRAIN_CYCLES=4.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_req;
  logic [31:0] flush_addr;
  logic        ex_brch;
  logic [31:0] ex_target;
  logic        dec_stall;
  logic        fetch_over;
  logic [34:0] ctrbus;
  logic        misalign;
  logic        halted;
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [34:0] IDLE_RUN = {3'b100, 32'h0};
  localparam logic [34:0] KILL_RUN = {3'b101, 32'h0};
  localparam logic [34:0] BUS_ZERO = 35'h0;

  fetch_ctrl #(.KILL_CYCLES(2), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .flush_req(flush_req), .flush_addr(flush_addr),
    .ex_brch(ex_brch), .ex_target(ex_target), .dec_stall(dec_stall),
    .fetch_over(fetch_over), .ctrbus(ctrbus), .misalign(misalign),
    .halted(halted), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush_req = 1'b0; flush_addr = '0; ex_brch = 1'b0;
    ex_target = '0; dec_stall = 1'b0; fetch_over = 1'b0;

    for (int i = 0; i < 3; i++) begin
      sample(); chk("reset_bus", ctrbus, BUS_ZERO);
      tick();
    end
    reset = 1'b0;
    sample();
    chk("post_reset_bus", ctrbus, IDLE_RUN);
    chk("post_reset_halted", 35'(halted), 35'(1'b0));
    chk("post_reset_misalign", 35'(misalign), 35'(1'b0));

    // Taken branch, two kill cycles
    tick(); ex_brch = 1'b1; ex_target = 32'h40;
    sample(); chk("br_redirect", ctrbus, {3'b111, 32'h40});
    tick(); ex_brch = 1'b0;
    sample(); chk("br_kill_hold", ctrbus, KILL_RUN);
    tick();
    sample(); chk("br_idle", ctrbus, IDLE_RUN);

    // Flush beats branch and stall
    tick(); flush_req = 1'b1; flush_addr = 32'h100; ex_brch = 1'b1; ex_target = 32'h80; dec_stall = 1'b1;
    sample(); chk("flush_prio", ctrbus, {3'b111, 32'h100});
    tick(); flush_req = 1'b0; ex_brch = 1'b0; dec_stall = 1'b0;
    sample(); chk("flush_kill_hold", ctrbus, KILL_RUN);
    tick();
    sample(); chk("flush_idle", ctrbus, IDLE_RUN);

    // Three-cycle stall
    for (int i = 0; i < 3; i++) begin
      tick(); dec_stall = 1'b1;
      sample(); chk("stall_bus", ctrbus, BUS_ZERO);
    end
    tick(); dec_stall = 1'b0;
    sample(); chk("stall_release", ctrbus, IDLE_RUN);
`ifdef FETCH_CTRL_PERF_EN
    chk("stall_cnt", 35'(stall_cnt), 35'(32'd3));
    chk("redirect_cnt_a", 35'(redirect_cnt), 35'(32'd2));
`else
    chk("stall_cnt_tied", 35'(stall_cnt), 35'(32'd0));
    chk("redirect_cnt_tied", 35'(redirect_cnt), 35'(32'd0));
`endif

    // Misaligned target
    tick(); ex_brch = 1'b1; ex_target = 32'h43;
    sample(); chk("mis_redirect", ctrbus, {3'b111, 32'h40});
    chk("mis_not_yet", 35'(misalign), 35'(1'b0));
    tick(); ex_brch = 1'b0; ex_target = '0;
    sample(); chk("mis_pulse", 35'(misalign), 35'(1'b1));
    chk("mis_kill_hold", ctrbus, KILL_RUN);
    tick();
    sample(); chk("mis_clear", 35'(misalign), 35'(1'b0));

    // fetch_over with a same-cycle redirect stays in RUN
    tick(); fetch_over = 1'b1; ex_brch = 1'b1; ex_target = 32'h200;
    sample(); chk("over_redirect", ctrbus, {3'b111, 32'h200});
    tick(); ex_brch = 1'b0;
    sample(); chk("over_still_run", ctrbus, KILL_RUN);
    tick();
    sample(); chk("drain_bus", ctrbus, BUS_ZERO);
    chk("drain_halted0", 35'(halted), 35'(1'b0));
    ex_brch = 1'b1; ex_target = 32'h300;
    #1; chk("drain_redirect", ctrbus, {3'b011, 32'h300});
    tick(); ex_brch = 1'b0;
    sample(); chk("drain_kill_hold", ctrbus, {3'b001, 32'h0});
    tick();
    sample(); chk("drain_halted1", 35'(halted), 35'(1'b0));
    tick();
    sample(); chk("drain_halted2", 35'(halted), 35'(1'b0));
    tick();
    sample(); chk("halted_set", 35'(halted), 35'(1'b1));
    chk("halted_bus", ctrbus, BUS_ZERO);
`ifdef FETCH_CTRL_PERF_EN
    chk("redirect_cnt_b", 35'(redirect_cnt), 35'(32'd5));
`endif
    ex_brch = 1'b1; ex_target = 32'h500;
    #1; chk("halted_ignores_br", ctrbus, BUS_ZERO);
    tick(); ex_brch = 1'b0;
    sample(); chk("halted_sticky", 35'(halted), 35'(1'b1));

    // Only reset leaves HALTED
    tick(); reset = 1'b1;
    sample(); chk("rst_again_bus", ctrbus, BUS_ZERO);
    tick(); reset = 1'b0; fetch_over = 1'b0;
    sample(); chk("rst_again_halted", 35'(halted), 35'(1'b0));
    chk("rst_again_run", ctrbus, IDLE_RUN);
    chk("rst_again_stallcnt", 35'(stall_cnt), 35'(32'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
